hex_display_ctrl: RTL
=====================

# hex_display_ctrl

Six-digit hexadecimal display controller for the DE10-Lite HEX0–HEX5 seven-segment bank. It accepts a 24-bit value through a ready/valid load handshake and sequences a single shared nibble decoder across the six digits, one digit per cycle. It commits all six digits to the display in the same cycle, so a mixed old/new display is never shown. It also provides optional leading-zero blanking, per-digit decimal points and per-digit blinking, and sits between user logic and the board's HEX pins.

## Interface
- BLINK_DIV, 25_000_000 — clock cycles per blink half-period; must be ≥ 2.
- MAX10_CLK1_50  in  1  — system clock; all logic is on its rising edge.
- RST  in  1  — asynchronous, active-high reset.
- VALUE  in  24  — value to display; nibble n drives HEXn.
- LOAD  in  1  — load request; accepted only on a cycle where READY=1.
- BLANK_LZ  in  1  — leading-zero blanking enable; sampled together with VALUE.
- DP  in  6  — decimal-point enables, one per digit; sampled with VALUE.
- BLINK_EN  in  6  — per-digit blink enable; live input, not sampled at load.
- READY  out  1  — controller idle and able to accept LOAD.
- HEX0..HEX5  out  8 each  — segment drives; active-low; bit7 = DP, bits6:0 = g..a.
- LEDR  out  10  — status: [9] busy, [8] blink phase, [7:0] committed VALUE[7:0].

## Operation
- **FSM states:** IDLE, SCAN, COMMIT.
- **IDLE**
  - READY=1.
  - LOAD=1 captures VALUE, BLANK_LZ and DP into shadow registers, sets idx=5 and clears the seen-nonzero flag; next state SCAN.
- **SCAN** (READY=0)
  - Decode shadow nibble[idx] and write the result to stage[idx].
  - Blank the digit when BLANK_LZ=1, no nonzero nibble has been seen above it, nibble=0 and idx≠0. A blanked digit is 7'h7F on bits6:0.
  - Set seen-nonzero when nibble≠0.
  - Bit7 = ~DP[idx]; the decimal point is honoured even on a blanked digit.
  - idx decrements; after idx=0, next state COMMIT.
- **COMMIT:** copy stage[5:0] into committed[5:0] and shadow VALUE[7:0] into LEDR[7:0]; next state IDLE.
- **LOAD while not in IDLE:** ignored; it is neither queued nor allowed to corrupt the shadow registers.
- **Segment patterns (active-high, before inversion):**
  - Digits 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Letters A–F: 77 7C 39 5E 79 71.
- **Blink counter**
  - Free-running from 0 to BLINK_DIV-1, then wraps to 0.
  - The phase bit toggles on each wrap.
- **Output register:** every cycle, HEXn ← (BLINK_EN[n] & phase) ? 8'hFF : committed[n].
- **LEDR:** LEDR[9] = (state≠IDLE); LEDR[8] = phase.

## Timing
- **Reset values**
  - HEX0–HEX5 = 8'hFF; committed and stage registers = 8'hFF.
  - LEDR = 0; READY = 1; state IDLE; blink counter = 0; phase = 0.
- **Reset mid-operation:** RST asserted in any state aborts the update immediately (asynchronous). Nothing partial is committed and the display goes blank.
- **Load latency**
  - LOAD sampled at edge 0.
  - SCAN occupies edges 1–6 (idx 5..0).
  - COMMIT at edge 7.
  - HEX pins change at edge 8.
- **READY:** low from after edge 0 until after edge 7, then high. The earliest next accept is at edge 8, giving a throughput of one load per 8 cycles.
- **All six digits change on the same edge.**
- **BLINK_EN change:** takes effect at the next edge (1-cycle latency).
- **Blink period:** 2×BLINK_DIV cycles, 50 % duty.
- **LEDR[9]:** combinational from state.

## Structure
- **Package hex_display_pkg:**
  - segment constants SEG_0..SEG_F (active-high) and SEG_BLANK;
  - the FSM state enum;
  - the NUM_DIGITS=6 constant.
- **Sub-module hex7seg_nibble:** combinational, 4-bit nibble in → 7-bit active-high segments out. Instantiated once as the shared decoder; the inversion to active-low is done in the controller.

## Test plan
- **Reset:** assert RST mid-cycle → HEX0–5 = FF immediately, READY=1, LEDR=0; hold 3 cycles, release, values unchanged.
- **Basic load with decimal point:**
  - Stimulus: VALUE=24'h0123AB, BLANK_LZ=0, DP=0, one LOAD pulse.
  - READY low for 7 cycles.
  - At edge 8: HEX5..HEX0 = C0, F9, A4, B0, 88, 83; LEDR[7:0] = AB.
  - Repeat with DP=6'b000100 and VALUE=24'h000800 → HEX2 = 00.
- **Leading-zero blanking** (BLANK_LZ=1):
  - VALUE=00000F → HEX5..1 = FF, HEX0 = 8E.
  - VALUE=000000 → HEX0 = C0, others FF.
  - VALUE=000100 → HEX2 = F9, HEX1 = HEX0 = C0.
- **Handshake:**
  - LOAD 123456, then LOAD FFFFFF 3 cycles later (while busy) → display 123456 (the second load is ignored).
  - LOAD FFFFFF after READY returns → all HEX = 8E.
- **Blink:**
  - Configuration: BLINK_DIV=4, BLINK_EN=6'b000001, display 000005.
  - HEX0 alternates 92 / FF every 4 cycles; HEX1–5 steady; LEDR[8] toggles every 4 cycles.
- **Reset during SCAN:**
  - Display 00000A, then LOAD 00000B, then assert RST on SCAN cycle 3.
  - Required: all HEX = FF, READY=1.
  - After release, LOAD 00000C → HEX0 = C6.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: segment patterns, FSM states and digit count for the hex display
package hex_display_pkg;
   localparam int NUM_DIGITS = 6;
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
endpackage

// File: rtl/hex7seg_nibble.sv
// hex7seg_nibble: combinational nibble to active-high seven-segment pattern
module hex7seg_nibble
   import hex_display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   // full 16-entry lookup; F doubles as the default so no latch is possible
   always_comb begin
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: six-digit hex display with shared decoder, atomic commit, LZ blanking and blink
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic        MAX10_CLK1_50,
   input  logic        RST,
   input  logic [23:0] VALUE,
   input  logic        LOAD,
   input  logic        BLANK_LZ,
   input  logic [5:0]  DP,
   input  logic [5:0]  BLINK_EN,
   output logic        READY,
   output logic [7:0]  HEX0,
   output logic [7:0]  HEX1,
   output logic [7:0]  HEX2,
   output logic [7:0]  HEX3,
   output logic [7:0]  HEX4,
   output logic [7:0]  HEX5,
   output logic [9:0]  LEDR
);
   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   state_t state;
   logic [NUM_DIGITS-1:0][3:0] sval;
   logic [NUM_DIGITS-1:0][7:0] stage, committed, hex;
   logic [5:0] dp;
   logic [2:0] idx;
   logic [7:0] led;
   logic [CW-1:0] cnt;
   logic [3:0] nib;
   logic [6:0] seg;
   logic blz, seen, phase, blank;

   assign nib   = sval[idx];
   assign blank = blz & ~seen & (nib == 4'd0) & (idx != 3'd0);
   assign READY = (state == IDLE);
   assign LEDR  = {state != IDLE, phase, led};
   assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = hex;

   hex7seg_nibble u_dec (.nib(nib), .seg(seg));

   // load/scan/commit sequencer: decodes one digit per cycle into stage, then commits all at once
   always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         sval      <= '0;
         blz       <= 1'b0;
         dp        <= '0;
         idx       <= '0;
         seen      <= 1'b0;
         stage     <= '1;
         committed <= '1;
         led       <= '0;
      end else begin
         case (state)
            IDLE: if (LOAD) begin
               sval  <= VALUE;
               blz   <= BLANK_LZ;
               dp    <= DP;
               idx   <= 3'd5;
               seen  <= 1'b0;
               state <= SCAN;
            end
            SCAN: begin
               stage[idx] <= {~dp[idx], ~(blank ? SEG_BLANK : seg)};
               seen       <= seen | (nib != 4'd0);
               idx        <= idx - 3'd1;
               state      <= (idx == 3'd0) ? COMMIT : SCAN;
            end
            COMMIT: begin
               committed <= stage;
               led       <= {sval[1], sval[0]};
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // free-running blink divider; phase flips each time the counter wraps
   always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
      if (RST) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         cnt   <= (cnt == CW'(BLINK_DIV - 1)) ? '0 : cnt + 1'b1;
         phase <= (cnt == CW'(BLINK_DIV - 1)) ? ~phase : phase;
      end
   end

   // registered pin drive with per-digit blink override
   always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
      if (RST) hex <= '1;
      else for (int i = 0; i < NUM_DIGITS; i++) hex[i] <= (BLINK_EN[i] & phase) ? 8'hFF : committed[i];
   end
endmodule
